mrmola_blink_top: RTL and testbench
===================================

Name: mrmola_blink_top

Overview:
- Top-level tile for the small blinker design, built on the standard tile pin-out: dedicated in/out bytes plus a bidirectional byte.
- Holds a free-running 16-bit counter and a blinker that derives a square-wave LED signal from a selectable counter bit.
- The counter value is exposed on the output pins for observation.

Parameters:
- COUNT_WIDTH, 16, counter width in bits (fixed at 16 for the pin mapping below).
- TAP_SEL_WIDTH, 4, width of the blink tap select field; selects counter bit 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  design enable; counting only while 1.
- ui_in  in  8  [3:0] blink tap select; [6:4] unused; [7] hold (1 = freeze counter).
- uo_out  out  8  [0] blink; [7:1] counter[15:9].
- uio_in  in  8  unused, ignored.
- uio_out  out  8  counter[7:0].
- uio_oe  out  8  constant 8'hFF (all bidirectional pins driven as outputs).

Behaviour:
- Reset (rst=1 at a rising edge): counter <= 16'h0000 and blink <= 0. Reset has priority over ena and hold. uio_oe stays 8'hFF during and after reset.
- Count: at each rising edge with rst=0, ena=1 and ui_in[7]=0, counter <= counter + 1, modulo 2^16.
  - 16'hFFFF wraps to 16'h0000 with no flag or stall.
  - Otherwise the counter holds its value.
- Blink:
  - Registered: at each rising edge with rst=0, blink <= counter[ui_in[3:0]], using the counter value before that edge's update.
  - blink therefore lags the selected counter bit by one cycle.
  - blink updates even while the counter is held or ena=0; it then stays constant because the counter is frozen.
- Tap select is sampled every cycle. A change takes effect at the next edge, with no glitch filtering.
- Outputs are combinational from registers only: uo_out = {counter[15:9], blink}, uio_out = counter[7:0].
- Reset mid-operation: any count value returns to 0 at the first edge with rst=1. Counting resumes at the first edge with rst=0, giving counter = 1 after that edge.
- Unused inputs (uio_in, ui_in[6:4]) have no effect on any output.

Decomposition:
- Shared package:
  - COUNT_WIDTH and TAP_SEL_WIDTH constants.
  - Pin-index constants: HOLD_BIT=7, BLINK_OUT_BIT=0.
- Sub-module mrmola_counter: 16-bit enable/hold counter with synchronous reset.
- The blink register and tap mux are small enough to live in the top.

Test Plan:
- Reset: rst=1 for 3 cycles, ena=1 -> uo_out=8'h00, uio_out=8'h00, uio_oe=8'hFF.
- Count: release rst, ena=1, ui_in=8'h00, run 300 edges -> uio_out=8'h2C (300 mod 256). After 512 edges -> uo_out[7:1]=7'h01.
- Blink tap: ui_in[3:0]=0 -> blink toggles every cycle, equal to the previous cycle's counter[0]. With ui_in[3:0]=3, blink period is 16 cycles (8 high, 8 low).
- Hold: at count 16'h0040 set ui_in[7]=1 for 10 edges -> uio_out stays 8'h40. Repeat with ena=0 -> same. Release -> next edge 8'h41.
- Wrap: run 65536 edges from reset release -> counter back to 16'h0000 (uo_out[7:1]=0, uio_out=0). The next edge gives 16'h0001.
- Mid-op reset: assert rst at count 16'h1234 with hold=1 and ena=1 -> next edge counter=0, blink=0 (reset beats hold).

Source files
------------

// File: rtl/mrmola_blink_pkg.sv
// rtl/mrmola_blink_pkg.sv - shared constants and types for the blinker tile
package mrmola_blink_pkg;
  localparam int COUNT_WIDTH   = 16;
  localparam int TAP_SEL_WIDTH = 4;
  localparam int HOLD_BIT      = 7;
  localparam int BLINK_OUT_BIT = 0;

  typedef logic [COUNT_WIDTH-1:0]   count_t;
  typedef logic [TAP_SEL_WIDTH-1:0] tap_sel_t;
endpackage

// File: rtl/mrmola_counter.sv
// rtl/mrmola_counter.sv - free-running counter with enable and synchronous reset
module mrmola_counter
  import mrmola_blink_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output count_t count
);

  count_t count_q;
  count_t count_d;

  // Wraps modulo 2^COUNT_WIDTH with no flag
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + count_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mrmola_blink_top.sv
// rtl/mrmola_blink_top.sv - tile top: counter plus blinker on a selectable counter bit
module mrmola_blink_top
  import mrmola_blink_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  count_t   count;
  tap_sel_t tap_sel;
  logic     count_en;
  logic     blink_q;
  logic     blink_d;
  logic     unused_inputs;

  assign tap_sel  = ui_in[TAP_SEL_WIDTH-1:0];
  assign count_en = ena & ~ui_in[HOLD_BIT];

  mrmola_counter u_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (count_en),
    .count (count)
  );

  // Samples the pre-update counter, so blink lags the tapped bit by one cycle
  always_comb begin
    blink_d = count[tap_sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  always_comb begin
    uo_out                = {count[COUNT_WIDTH-1:9], 1'b0};
    uo_out[BLINK_OUT_BIT] = blink_q;
    uio_out               = count[7:0];
    uio_oe                = 8'hFF;
  end

  assign unused_inputs = &{1'b0, uio_in, ui_in[6:4], count[8]};

endmodule

// File: tb/tb_mrmola_blink_top.sv
// tb/tb_mrmola_blink_top.sv - randomized self-checking bench with arithmetic reference model
module tb_mrmola_blink_top;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_fail;
  int cnt_m;
  int blink_m;

  mrmola_blink_top dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    check("uo_out", {24'h0, uo_out}, ((cnt_m >> 9) << 1) | blink_m);
    check("uio_out", {24'h0, uio_out}, cnt_m % 256);
    check("uio_oe", {24'h0, uio_oe}, 32'hFF);
  endtask

  // One rising edge; the model applies the stated rules with plain arithmetic
  task automatic step(input bit chk);
    @(posedge clk);
    if (rst) begin
      cnt_m   = 0;
      blink_m = 0;
    end else begin
      blink_m = (cnt_m >> ui_in[3:0]) & 1;
      if (ena && !ui_in[7]) cnt_m = (cnt_m + 1) % 65536;
    end
    @(negedge clk);
    if (chk) check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
  endtask

  initial begin
    int highs;
    n_checks = 0;
    n_fail   = 0;
    cnt_m    = 0;
    blink_m  = 0;
    rst      = 1'b1;
    ena      = 1'b1;
    ui_in    = 8'h00;
    uio_in   = 8'h5A;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) step(1'b1);
    check("rst_uo", {24'h0, uo_out}, 32'h00);
    check("rst_uio", {24'h0, uio_out}, 32'h00);
    check("rst_oe", {24'h0, uio_oe}, 32'hFF);

    // Count with tap 0: blink compared every cycle via the model
    rst = 1'b0;
    for (int i = 0; i < 300; i++) step(1'b1);
    check("count300", {24'h0, uio_out}, 32'h2C);
    for (int i = 300; i < 512; i++) step(1'b1);
    check("count512_hi", {25'h0, uo_out[7:1]}, 32'h01);

    // Tap 3: over 32 cycles blink is high for exactly 16
    ui_in = 8'h03;
    step(1'b1);
    highs = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b1);
      highs += uo_out[0];
    end
    check("tap3_duty", highs, 16);

    // Hold at 0x40, then ena=0, then release
    ui_in = 8'h00;
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b0);
    check("at_0x40", {24'h0, uio_out}, 32'h40);
    ui_in = 8'h80;
    for (int i = 0; i < 10; i++) step(1'b1);
    check("hold_0x40", {24'h0, uio_out}, 32'h40);
    ui_in = 8'h00;
    ena   = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1);
    check("ena0_0x40", {24'h0, uio_out}, 32'h40);
    ena = 1'b1;
    step(1'b1);
    check("release_0x41", {24'h0, uio_out}, 32'h41);

    // Full wrap from reset release
    do_reset();
    for (int i = 0; i < 65536; i++) step(1'b0);
    check("wrap_hi", {25'h0, uo_out[7:1]}, 32'h0);
    check("wrap_lo", {24'h0, uio_out}, 32'h0);
    step(1'b0);
    check("wrap_next", {24'h0, uio_out}, 32'h01);

    // Reset beats hold at 0x1234
    do_reset();
    for (int i = 0; i < 16'h1234; i++) step(1'b0);
    check("at_1234", {16'h0, uo_out[7:1], 1'b0, uio_out}, 32'h1234);
    ui_in = 8'h80;
    rst   = 1'b1;
    step(1'b1);
    check("midrst_uo", {24'h0, uo_out}, 32'h00);
    check("midrst_uio", {24'h0, uio_out}, 32'h00);
    rst   = 1'b0;
    ui_in = 8'h00;
    step(1'b1);
    check("resume_1", {24'h0, uio_out}, 32'h01);

    // Randomized phase, including unused inputs toggling
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      ena    = ($urandom_range(0, 4) != 0);
      ui_in  = 8'($urandom);
      ui_in[7] = ($urandom_range(0, 4) == 0);
      uio_in = 8'($urandom);
      step(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
